// File: rtl/host_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : host_mem_bridge
// Description : Host request port onto instruction/data BRAMs; one request in
//               flight, byte-lane writes, registered read capture.
// Revision    : 1.0 - initial release
// ============================================================================
module host_mem_bridge #(
    parameter  int WIDTH     = 32,
    parameter  int SIZE      = 256,
    parameter  int NUM_COL   = 4,
    parameter  int COL_WIDTH = 8,
    localparam int LOGSIZE   = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_run,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [LOGSIZE+2:0]   host_addr,
    input  logic [NUM_COL-1:0]   host_wr_en,
    input  logic [WIDTH-1:0]     host_wdata,
    output logic                 host_resp_valid,
    input  logic                 host_resp_ready,
    output logic [WIDTH-1:0]     host_rdata,
    output logic                 host_err,
    output logic [LOGSIZE-1:0]   imem_addr,
    output logic [WIDTH-1:0]     imem_din,
    output logic [NUM_COL-1:0]   imem_we,
    input  logic [WIDTH-1:0]     imem_dout,
    output logic [LOGSIZE-1:0]   dmem_addr,
    output logic [WIDTH-1:0]     dmem_din,
    output logic [NUM_COL-1:0]   dmem_we,
    input  logic [WIDTH-1:0]     dmem_dout
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_sel_dmem;
    logic [LOGSIZE-1:0]   r_word;
    logic [NUM_COL-1:0]   r_wr_en;
    logic [WIDTH-1:0]     r_wdata;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_err;
    logic [WIDTH-1:0]     w_din;
    logic                 w_accept;
    logic                 w_misaligned;

    assign host_ready      = (r_state == IDLE) && !cpu_run && !reset;
    assign w_accept        = host_valid && host_ready;
    assign w_misaligned    = (host_addr[1:0] != 2'b00);
    assign host_resp_valid = (r_state == RESP);
    assign host_rdata      = r_rdata;
    assign host_err        = r_err;

    // Disabled lanes present zero on the data bus.
    for (genvar k = 0; k < NUM_COL; k++) begin : g_lane
        assign w_din[k*COL_WIDTH +: COL_WIDTH] =
            r_wr_en[k] ? r_wdata[k*COL_WIDTH +: COL_WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misaligned)        w_next = RESP;
                    else if (|host_wr_en)    w_next = WR;
                    else                     w_next = RD;
                end
            end
            WR:      w_next = RESP;
            RD:      w_next = CAP;
            CAP:     w_next = RESP;
            RESP:    if (host_resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_dmem <= 1'b0;
            r_word     <= '0;
            r_wr_en    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sel_dmem <= host_addr[LOGSIZE+2];
                        r_word     <= host_addr[LOGSIZE+1:2];
                        r_wr_en    <= host_wr_en;
                        r_wdata    <= host_wdata;
                        r_rdata    <= '0;
                        r_err      <= w_misaligned;
                    end
                end
                WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                CAP: begin
                    r_rdata <= r_sel_dmem ? dmem_dout : imem_dout;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Memory buses are idle (all zero) except during WR/RD, and forced idle in reset.
    always_comb begin
        imem_addr = '0;
        imem_din  = '0;
        imem_we   = '0;
        dmem_addr = '0;
        dmem_din  = '0;
        dmem_we   = '0;
        if (!reset) begin
            if (r_state == WR) begin
                if (r_sel_dmem) begin
                    dmem_addr = r_word;
                    dmem_din  = w_din;
                    dmem_we   = r_wr_en;
                end else begin
                    imem_addr = r_word;
                    imem_din  = w_din;
                    imem_we   = r_wr_en;
                end
            end else if (r_state == RD) begin
                if (r_sel_dmem) dmem_addr = r_word;
                else            imem_addr = r_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_host_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_mem_bridge
// Description : Scoreboard bench for host_mem_bridge with behavioural BRAMs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_mem_bridge;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 256;
    localparam int NUM_COL = 4;
    localparam int LOGSIZE = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cpu_run;
    logic                 host_valid;
    logic                 host_ready;
    logic [LOGSIZE+2:0]   host_addr;
    logic [NUM_COL-1:0]   host_wr_en;
    logic [WIDTH-1:0]     host_wdata;
    logic                 host_resp_valid;
    logic                 host_resp_ready;
    logic [WIDTH-1:0]     host_rdata;
    logic                 host_err;
    logic [LOGSIZE-1:0]   imem_addr, dmem_addr;
    logic [WIDTH-1:0]     imem_din, dmem_din, imem_dout, dmem_dout;
    logic [NUM_COL-1:0]   imem_we, dmem_we;

    int checks   = 0;
    int failures = 0;
    int imem_we_cycles = 0;
    int dmem_we_cycles = 0;
    logic [WIDTH:0] sb_q[$];

    logic [WIDTH-1:0] imem_mem [SIZE];
    logic [WIDTH-1:0] dmem_mem [SIZE];

    host_mem_bridge #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL), .COL_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .cpu_run(cpu_run),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_wr_en(host_wr_en), .host_wdata(host_wdata),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_rdata(host_rdata), .host_err(host_err),
        .imem_addr(imem_addr), .imem_din(imem_din), .imem_we(imem_we), .imem_dout(imem_dout),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_we(dmem_we), .dmem_dout(dmem_dout)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < SIZE; i++) begin
            imem_mem[i] = '0;
            dmem_mem[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NUM_COL; k++) begin
            if (imem_we[k]) imem_mem[imem_addr][k*8 +: 8] <= imem_din[k*8 +: 8];
            if (dmem_we[k]) dmem_mem[dmem_addr][k*8 +: 8] <= dmem_din[k*8 +: 8];
        end
        imem_dout <= imem_mem[imem_addr];
        dmem_dout <= dmem_mem[dmem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (imem_we != '0) imem_we_cycles++;
        if (dmem_we != '0) dmem_we_cycles++;
        if (!reset && host_resp_valid && host_resp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got rdata=%0h err=%0b expected none", host_rdata, host_err);
            end else begin
                logic [WIDTH:0] e;
                e = sb_q.pop_front();
                check("resp", {31'd0, host_err, host_rdata}, {31'd0, e});
            end
        end
    end

    task automatic issue(input logic [LOGSIZE+2:0] a, input logic [3:0] we,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat);
        int n;
        int i0, d0;
        logic is_dmem;
        is_dmem = a[LOGSIZE+2];
        sb_q.push_back({exp_err, exp_rd});
        host_addr  = a;
        host_wr_en = we;
        host_wdata = d;
        host_valid = 1'b1;
        n = 0;
        while (!host_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!host_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got ready=0 expected 1 addr=%0h", a);
        end
        i0 = imem_we_cycles;
        d0 = dmem_we_cycles;
        @(posedge clk); #1;
        host_valid = 1'b0;
        n = 1;
        while (!host_resp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("imem_we_pulses", 64'(imem_we_cycles - i0),
              64'((!exp_err && we != 0 && !is_dmem) ? 1 : 0));
        check("dmem_we_pulses", 64'(dmem_we_cycles - d0),
              64'((!exp_err && we != 0 && is_dmem) ? 1 : 0));
        if (host_resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        reset = 1'b1; cpu_run = 1'b0; host_valid = 1'b0; host_addr = '0;
        host_wr_en = '0; host_wdata = '0; host_resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(host_ready), 64'd0);
        check("rst_resp_valid", 64'(host_resp_valid), 64'd0);
        check("rst_rdata_err", {31'd0, host_err, host_rdata}, 64'd0);
        check("rst_mem_bus", {imem_addr, imem_we, dmem_addr, dmem_we}, 64'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 64'(host_ready), 64'd1);
        @(posedge clk); #1;

        // Fill then readback: data = byte address.
        for (int a = 0; a < 2048; a += 4) issue(11'(a), 4'hF, 32'(a), 32'd0, 1'b0, 2);
        for (int a = 0; a < 2048; a += 4) issue(11'(a), 4'h0, 32'd0, 32'(a), 1'b0, 3);

        // Byte lanes.
        issue(11'h404, 4'hF, 32'hAABBCCDD, 32'd0, 1'b0, 2);
        issue(11'h404, 4'b0101, 32'h11223344, 32'd0, 1'b0, 2);
        issue(11'h404, 4'h0, 32'd0, 32'hAA22CC44, 1'b0, 3);

        // Misaligned write is rejected without touching memory.
        issue(11'h006, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1, 1);
        issue(11'h004, 4'h0, 32'd0, 32'h4, 1'b0, 3);
        issue(11'h7FC, 4'h0, 32'd0, 32'h7FC, 1'b0, 3);

        // Backpressure on the response channel.
        host_resp_ready = 1'b0;
        issue(11'h008, 4'h0, 32'd0, 32'h8, 1'b0, 3);
        held = host_rdata;
        check("bp_first_rdata", 64'(held), 64'h8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {30'd0, host_resp_valid, host_ready, host_rdata}, {30'd0, 1'b1, 1'b0, 32'h8});
        end
        host_resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done", {31'd0, host_resp_valid, 32'(sb_q.size())}, 64'd0);

        // cpu_run gates acceptance.
        cpu_run = 1'b1; host_valid = 1'b1; host_addr = 11'h00C; host_wr_en = 4'hF; host_wdata = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("run_block", {29'd0, host_ready, host_resp_valid, imem_we, dmem_we, imem_addr, dmem_addr},
                  64'd0);
        end
        cpu_run = 1'b0;
        #1;
        check("run_release_ready", 64'(host_ready), 64'd1);
        issue(11'h00C, 4'h0, 32'd0, 32'hC, 1'b0, 3);

        // Reset during the WR cycle drops the write and the response.
        host_addr = 11'h010; host_wr_en = 4'hF; host_wdata = 32'hDEADBEEF; host_valid = 1'b1;
        @(posedge clk); #1;
        host_valid = 1'b0;
        check("wr_cycle_we", 64'(imem_we), 64'hF);
        reset = 1'b1;
        #1;
        check("rst_we_gated", {imem_we, dmem_we}, 64'd0);
        @(posedge clk); #1;
        check("in_rst", {30'd0, host_resp_valid, host_ready, imem_we, dmem_we}, 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(host_ready), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("no_resp_after_rst", 64'(host_resp_valid), 64'd0);
        end
        issue(11'h010, 4'h0, 32'd0, 32'h10, 1'b0, 3);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
